// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, shared sample-tick prescaler and
// per-button debounce counters producing a clean level plus press/release pulses.

module button_debounce_ch #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic sync_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  localparam logic [3:0] STABLE_L = 4'(STABLE_SAMPLES);

  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick_i) begin
      if (sync_i == level_q) begin
        cnt_d = '0;
      end else if (cnt_q + 4'd1 == STABLE_L) begin
        // enough consecutive disagreeing samples: commit and flag the edge direction
        level_d   = sync_i;
        cnt_d     = '0;
        press_d   = sync_i;
        release_d = ~sync_i;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule

module button_conditioner #(
  parameter int NUM_BUTTONS    = 4,
  parameter int TICK_BITS      = 16,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic                   sample_tick
);
  logic [TICK_BITS-1:0]   presc_q, presc_d;
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;

  assign presc_d     = presc_q + TICK_BITS'(1);
  assign sample_tick = &presc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      presc_q <= presc_d;
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_debounce_ch #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick_i   (sample_tick),
      .sync_i   (sync2_q[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with TICK_BITS=3 (tick every 8 clocks), STABLE_SAMPLES=3.
// Cycle c is the interval ending at clock edge c; edge 0 is the first rising edge after reset release.

module tb_button_conditioner;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = 4'b0;
  logic [3:0] btn_level, btn_press, btn_release;
  logic       sample_tick;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  button_conditioner #(.NUM_BUTTONS(4), .TICK_BITS(3), .STABLE_SAMPLES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  // Advance one edge; afterwards the outputs show cycle 'cyc' and inputs set now hit edge 'cyc'.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic exp_tick;
    btn_raw = 4'b0;
    do_reset();
    n_vec++;
    if ({btn_level, btn_press, btn_release, sample_tick} !== 13'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0", {btn_level, btn_press, btn_release, sample_tick});
    end
    while (cyc < 40) begin
      step();
      exp_tick = ((cyc % 8) == 7);
      n_vec++;
      if (sample_tick !== exp_tick) begin
        n_err++;
        $display("FAIL prescaler_tick cyc %0d: got %b want %b", cyc, sample_tick, exp_tick);
      end
      n_vec++;
      if ({btn_level, btn_press, btn_release} !== 12'b0) begin
        n_err++;
        $display("FAIL idle_outputs cyc %0d: got %b want 0", cyc, {btn_level, btn_press, btn_release});
      end
    end
  endtask

  task automatic test_clean_press();
    int rise = -1, pcnt = 0, pcyc = -1;
    bit other = 1'b0;
    btn_raw = 4'b0;
    do_reset();
    while (cyc < 20) step();
    btn_raw = 4'b0001;
    while (cyc < 60) begin
      step();
      if (btn_level[0] && rise < 0) rise = cyc;
      if (btn_press[0]) begin pcnt++; pcyc = cyc; end
      if (btn_level[3:1] != 3'b0 || btn_press[3:1] != 3'b0 || btn_release != 4'b0) other = 1'b1;
    end
    n_vec++;
    if (rise != 40 && rise != 48) begin
      n_err++;
      $display("FAIL press_latency: level rose at cyc %0d want 40 or 48", rise);
    end
    n_vec++;
    if (pcnt != 1) begin
      n_err++;
      $display("FAIL press_pulse_count: got %0d want 1", pcnt);
    end
    n_vec++;
    if (pcyc != rise) begin
      n_err++;
      $display("FAIL press_pulse_cycle: got %0d want %0d", pcyc, rise);
    end
    n_vec++;
    if (other !== 1'b0) begin
      n_err++;
      $display("FAIL press_other_bits: got 1 want 0");
    end
  endtask

  task automatic test_bounce();
    bit seen = 1'b0;
    btn_raw = 4'b0;
    do_reset();
    while (cyc < 3) step();
    btn_raw = 4'b0010;
    while (cyc < 13) step();
    btn_raw = 4'b0000;
    while (cyc < 60) begin
      step();
      if (btn_level[1] || btn_press[1] || btn_release[1]) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_rejected: got activity 1 want 0");
    end
  endtask

  task automatic test_release();
    int rise = -1, fall = -1, pcnt = 0, rcnt = 0, rcyc = -1;
    btn_raw = 4'b0;
    do_reset();
    btn_raw = 4'b0100;
    while (cyc < 80) begin
      step();
      if (btn_press[2]) pcnt++;
      if (btn_release[2]) begin rcnt++; rcyc = cyc; end
      if (btn_level[2] && rise < 0) begin rise = cyc; btn_raw = 4'b0000; end
      if (rise >= 0 && !btn_level[2] && fall < 0) fall = cyc;
    end
    n_vec++;
    if (rise != 24) begin
      n_err++;
      $display("FAIL release_setup_rise: got %0d want 24", rise);
    end
    n_vec++;
    if (fall != 48 && fall != 56) begin
      n_err++;
      $display("FAIL release_latency: got %0d want 48 or 56", fall);
    end
    n_vec++;
    if (rcnt != 1 || rcyc != fall) begin
      n_err++;
      $display("FAIL release_pulse: count %0d at %0d want 1 at %0d", rcnt, rcyc, fall);
    end
    n_vec++;
    if (pcnt != 1) begin
      n_err++;
      $display("FAIL release_no_press: press count %0d want 1", pcnt);
    end
  endtask

  task automatic test_simultaneous();
    btn_raw = 4'b0;
    do_reset();
    btn_raw = 4'b1010;
    while (cyc < 23) step();
    n_vec++;
    if (btn_level !== 4'b0000) begin
      n_err++;
      $display("FAIL simul_pre_level: got %b want 0000", btn_level);
    end
    step();
    n_vec++;
    if (btn_level !== 4'b1010) begin
      n_err++;
      $display("FAIL simul_level: got %b want 1010", btn_level);
    end
    n_vec++;
    if (btn_press !== 4'b1010) begin
      n_err++;
      $display("FAIL simul_press: got %b want 1010", btn_press);
    end
    step();
    n_vec++;
    if (btn_press !== 4'b0000 || btn_level !== 4'b1010) begin
      n_err++;
      $display("FAIL simul_after: press %b level %b want 0000 1010", btn_press, btn_level);
    end
  endtask

  task automatic test_reset_mid();
    btn_raw = 4'b0;
    do_reset();
    btn_raw = 4'b0010;
    while (cyc < 24) step();
    btn_raw = 4'b1010;
    while (cyc < 40) step();
    n_vec++;
    if (btn_level !== 4'b0010) begin
      n_err++;
      $display("FAIL midreset_pre_level: got %b want 0010", btn_level);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({btn_level, btn_press, btn_release, sample_tick} !== 13'b0) begin
      n_err++;
      $display("FAIL midreset_async_clear: got %b want 0", {btn_level, btn_press, btn_release, sample_tick});
    end
    do_reset();
    while (cyc < 16) step();
    n_vec++;
    if (btn_level !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_history_cleared: got %b want 0000", btn_level);
    end
    while (cyc < 23) step();
    n_vec++;
    if (btn_level !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_pre_level2: got %b want 0000", btn_level);
    end
    step();
    n_vec++;
    if (btn_level !== 4'b1010 || btn_press !== 4'b1010) begin
      n_err++;
      $display("FAIL midreset_fresh_rise: level %b press %b want 1010 1010", btn_level, btn_press);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
